// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Round-robin arbitration in IDLE, operand capture on accept, one-cycle
// execute, then a registered and tagged response held under valid/ready.
// Optional feature macro: ALU_SHARE_OPCOUNT_EN builds a saturating 16-bit
// completed-operation counter; without it op_count is tied to zero.

module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_src1,
    input  logic [DATA_W*NUM_REQ-1:0] req_src2,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_zero,
    output logic                      busy,
    output logic [15:0]               op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Shared ALU behaviour; undefined opcodes yield zero (and thus zero flag set).
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        case (op)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = a ^ b;
            3'b101:  res = ~(a | b);
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] src1_r;
    logic [DATA_W-1:0] src2_r;
    logic              resp_valid_r;
    logic [ID_W-1:0]   resp_id_r;
    logic [DATA_W-1:0] resp_result_r;
    logic              resp_zero_r;

    logic              found_s;
    logic [ID_W-1:0]   winner_s;
    logic [ID_W:0]     idx_s;
    logic [NUM_REQ-1:0] grant_s;
    logic              accept_s;
    logic [2:0]        op_sel_s;
    logic [DATA_W-1:0] src1_sel_s;
    logic [DATA_W-1:0] src2_sel_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_zero_s;
    logic [ID_W-1:0]   ptr_next_s;

    // Round-robin search starting at the pointer; first pending request wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        idx_s    = {(ID_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[ID_W-1:0];
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // One-hot grant, only offered in IDLE and never while reset is held.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ST_IDLE) && found_s && !rst && (winner_s == ID_W'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Operand mux selecting the winner's op and sources for capture.
    always_comb begin
        op_sel_s   = 3'b000;
        src1_sel_s = {DATA_W{1'b0}};
        src2_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                op_sel_s   = req_op[3*i +: 3];
                src1_sel_s = req_src1[DATA_W*i +: DATA_W];
                src2_sel_s = req_src2[DATA_W*i +: DATA_W];
            end else begin
                op_sel_s   = op_sel_s;
                src1_sel_s = src1_sel_s;
                src2_sel_s = src2_sel_s;
            end
        end
    end

    // Pointer advances past the winner, wrapping after the last requester.
    always_comb begin
        if (winner_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = winner_s + ID_W'(1);
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && found_s;
    assign alu_res_s  = alu_calc(op_r, src1_r, src2_r);
    assign alu_zero_s = (alu_res_s == {DATA_W{1'b0}});

    // Control FSM: capture on accept, execute from latched operands, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= {ID_W{1'b0}};
            id_r          <= {ID_W{1'b0}};
            op_r          <= 3'b000;
            src1_r        <= {DATA_W{1'b0}};
            src2_r        <= {DATA_W{1'b0}};
            resp_valid_r  <= 1'b0;
            resp_id_r     <= {ID_W{1'b0}};
            resp_result_r <= {DATA_W{1'b0}};
            resp_zero_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= op_sel_s;
                        src1_r  <= src1_sel_s;
                        src2_r  <= src2_sel_s;
                        id_r    <= winner_s;
                        ptr_r   <= ptr_next_s;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result_r <= alu_res_s;
                    resp_zero_r   <= alu_zero_s;
                    resp_id_r     <= id_r;
                    resp_valid_r  <= 1'b1;
                    state_r       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_OPCOUNT_EN
    logic [15:0] op_count_r;

    // Completed-operation counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= 16'h0000;
        end else if ((state_r == ST_RESP) && resp_valid_r && resp_ready &&
                     (op_count_r != 16'hFFFF)) begin
            op_count_r <= op_count_r + 16'h0001;
        end
    end

    assign op_count = op_count_r;
`else
    assign op_count = 16'h0000;
`endif

    assign req_ready   = grant_s;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_result = resp_result_r;
    assign resp_zero   = resp_zero_r;
    assign busy        = (state_r != ST_IDLE);

endmodule
